// File: rtl/tt_um_hoene_frame_controller.sv
// Frame sequencer: captures the first 32-bit word of a frame as this LED's colour,
// forwards later bits, commits at idle timeout. Parity check enabled by FRAME_CTRL_PARITY_EN.
module tt_um_hoene_frame_controller #(
  parameter int unsigned IDLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_data,
  input  logic       in_clk,
  input  logic       in_error,
  output logic [9:0] pwm_red,
  output logic [9:0] pwm_green,
  output logic [9:0] pwm_blue,
  output logic       pwm_set,
  output logic       fwd_data,
  output logic       fwd_clk,
  output logic       error,
  output logic [1:0] state
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDLE_W = 8;
  localparam int unsigned COL_W  = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FORWARD = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_shift, w_shift_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [IDLE_W-1:0]   r_idle, w_idle_nxt;
  logic [COL_W-1:0]    r_pending, w_pending_nxt;
  logic                r_pending_valid, w_pending_valid_nxt;
  logic [COL_W-1:0]    r_pwm, w_pwm_nxt;
  logic                r_pwm_set, w_pwm_set_nxt;
  logic                r_fwd_clk, w_fwd_clk_nxt;
  logic                r_fwd_data, w_fwd_data_nxt;
  logic                r_error, w_error_nxt;

  logic [WORD_W-1:0]   w_word;
  logic                w_timeout;
  logic                w_parity_ok;
  logic                w_unused_msb;

  assign w_word       = {r_shift[WORD_W-2:0], in_data};
  assign w_unused_msb = r_shift[WORD_W-1];
  // Timeout is the single cycle in which the idle counter steps onto IDLE_CYCLES.
  assign w_timeout    = !in_clk && (r_idle == IDLE_W'(IDLE_CYCLES - 1));

`ifdef FRAME_CTRL_PARITY_EN
  assign w_parity_ok = ~(^w_word);
`else
  assign w_parity_ok = 1'b1;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_shift         <= '0;
      r_count         <= '0;
      r_idle          <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_pwm           <= '0;
      r_pwm_set       <= 1'b0;
      r_fwd_clk       <= 1'b0;
      r_fwd_data      <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_shift         <= w_shift_nxt;
      r_count         <= w_count_nxt;
      r_idle          <= w_idle_nxt;
      r_pending       <= w_pending_nxt;
      r_pending_valid <= w_pending_valid_nxt;
      r_pwm           <= w_pwm_nxt;
      r_pwm_set       <= w_pwm_set_nxt;
      r_fwd_clk       <= w_fwd_clk_nxt;
      r_fwd_data      <= w_fwd_data_nxt;
      r_error         <= w_error_nxt;
    end
  end

  // Next-state and next-output logic; in_error overrides everything, including a coincident bit.
  always_comb begin
    w_state_nxt         = r_state;
    w_shift_nxt         = r_shift;
    w_count_nxt         = r_count;
    w_idle_nxt          = r_idle;
    w_pending_nxt       = r_pending;
    w_pending_valid_nxt = r_pending_valid;
    w_pwm_nxt           = r_pwm;
    w_pwm_set_nxt       = 1'b0;
    w_fwd_clk_nxt       = 1'b0;
    w_fwd_data_nxt      = r_fwd_data;
    w_error_nxt         = r_error;

    if (in_clk) begin
      w_idle_nxt = '0;
    end else if (r_idle != IDLE_W'(IDLE_CYCLES)) begin
      w_idle_nxt = r_idle + IDLE_W'(1);
    end

    if (in_error) begin
      w_error_nxt         = 1'b1;
      w_pending_valid_nxt = 1'b0;
      w_state_nxt         = ST_ERROR;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_clk) begin
            w_error_nxt = 1'b0;
            w_shift_nxt = w_word;
            w_count_nxt = CNT_W'(1);
            w_state_nxt = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (in_clk) begin
            w_shift_nxt = w_word;
            w_count_nxt = r_count + CNT_W'(1);
            if (r_count == CNT_W'(WORD_W - 1)) begin
              if (w_parity_ok) begin
                w_pending_nxt       = w_word[WORD_W-1:2];
                w_pending_valid_nxt = 1'b1;
                w_state_nxt         = ST_FORWARD;
              end else begin
                w_error_nxt = 1'b1;
                w_state_nxt = ST_ERROR;
              end
            end
          end else if (w_timeout) begin
            w_error_nxt = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_FORWARD: begin
          if (in_clk) begin
            w_fwd_clk_nxt  = 1'b1;
            w_fwd_data_nxt = in_data;
          end else if (w_timeout) begin
            if (r_pending_valid) begin
              w_pwm_nxt     = r_pending;
              w_pwm_set_nxt = 1'b1;
            end
            w_pending_valid_nxt = 1'b0;
            w_state_nxt         = ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (w_timeout) begin
            w_pending_valid_nxt = 1'b0;
            w_state_nxt         = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign pwm_red   = r_pwm[29:20];
  assign pwm_green = r_pwm[19:10];
  assign pwm_blue  = r_pwm[9:0];
  assign pwm_set   = r_pwm_set;
  assign fwd_clk   = r_fwd_clk;
  assign fwd_data  = r_fwd_data;
  assign error     = r_error;
  assign state     = r_state;

endmodule

// File: tb/tb_tt_um_hoene_frame_controller.sv
// Bench for tt_um_hoene_frame_controller: directed frame table, randomized frames
// against a frame-level outcome model, plus timeout-latency and mid-frame reset sequences.
module tb_tt_um_hoene_frame_controller;

  localparam int unsigned IDLE = 64;
`ifdef FRAME_CTRL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_data, in_clk, in_error;
  logic [9:0] pwm_red, pwm_green, pwm_blue;
  logic       pwm_set, fwd_data, fwd_clk, error;
  logic [1:0] state;

  tt_um_hoene_frame_controller #(.IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_clk(in_clk), .in_error(in_error),
    .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue), .pwm_set(pwm_set),
    .fwd_data(fwd_data), .fwd_clk(fwd_clk), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  r, g, b;
    bit          good;
    int          nbits;
    int          nextra;
    logic [31:0] extra;
    int          err_at;
    bit          exp_commit;
    bit          exp_err;
    logic [1:0]  exp_state_mid;
    int          exp_nfwd;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  bit          last_clk = 1'b0, last_data = 1'b0, last_err = 1'b0;
  bit          fwd_q[$];
  int          set_cnt = 0;
  logic [29:0] exp_pwm = '0;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Input snapshot at each active edge, used to verify one-cycle forward latency.
  always @(posedge clk) begin
    last_clk  = in_clk;
    last_data = in_data;
    last_err  = in_error;
  end

  always @(negedge clk) begin
    if (fwd_clk === 1'b1) begin
      fwd_q.push_back(fwd_data);
      chk("fwd_follows_in_clk", 64'({1'b1, fwd_data}), 64'({last_clk & ~last_err, last_data}));
    end
    if (pwm_set === 1'b1) set_cnt++;
  end

  function automatic logic [31:0] mk_word(input logic [9:0] r, g, b, input bit good);
    logic [31:0] w;
    w    = {r, g, b, 2'b00};
    w[0] = (^w) ^ ~good;
    return w;
  endfunction

  function automatic vec_t mkv(input logic [9:0] r, g, b, input bit good, input int nbits,
                               input int nextra, input logic [31:0] extra, input int err_at,
                               input bit commit, input bit err, input logic [1:0] smid,
                               input int nfwd);
    vec_t v;
    v.r = r; v.g = g; v.b = b; v.good = good; v.nbits = nbits; v.nextra = nextra;
    v.extra = extra; v.err_at = err_at; v.exp_commit = commit; v.exp_err = err;
    v.exp_state_mid = smid; v.exp_nfwd = nfwd;
    return v;
  endfunction

  // Frame-level outcome: only a full, acceptable, uninterrupted first word ever commits.
  function automatic vec_t model(input vec_t v);
    bit accepted, inj;
    accepted        = (v.nbits == 32) && (!PAR_EN || v.good);
    inj             = (v.err_at >= 0);
    v.exp_commit    = accepted && !inj;
    v.exp_err       = !v.exp_commit;
    v.exp_state_mid = (v.nbits < 32) ? 2'd1 : ((!accepted || inj) ? 2'd3 : 2'd2);
    v.exp_nfwd      = accepted ? (inj ? v.err_at : v.nextra) : 0;
    return v;
  endfunction

  task automatic send_bit(input bit d, input bit err);
    @(posedge clk); #1;
    in_clk = 1'b1; in_data = d; in_error = err;
    @(posedge clk); #1;
    in_clk = 1'b0; in_error = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [31:0] word, got, want;
    word = mk_word(v.r, v.g, v.b, v.good);
    fwd_q.delete();
    set_cnt = 0;
    for (int i = 0; i < v.nbits; i++) begin
      gap();
      send_bit(word[31-i], 1'b0);
      if (i == 0) chk({tag, "_err_clr_first_bit"}, 64'(error), 64'(0));
    end
    for (int j = 0; j <= v.nextra; j++) begin
      if (j == v.err_at) begin gap(); send_bit(1'b1, 1'b1); end
      if (j < v.nextra) begin gap(); send_bit(v.extra[31-j], 1'b0); end
    end
    chk({tag, "_state_mid"}, 64'(state), 64'(v.exp_state_mid));
    repeat (IDLE + 4) @(posedge clk);
    #1;
    got  = '0;
    want = '0;
    for (int k = 0; k < v.exp_nfwd && k < fwd_q.size(); k++) begin
      got[31-k]  = fwd_q[k];
      want[31-k] = v.extra[31-k];
    end
    if (v.exp_commit) exp_pwm = {v.r, v.g, v.b};
    chk({tag, "_fwd_count"}, 64'(fwd_q.size()), 64'(v.exp_nfwd));
    chk({tag, "_fwd_data"}, 64'(got), 64'(want));
    chk({tag, "_pwm_set_count"}, 64'(set_cnt), 64'(v.exp_commit));
    chk({tag, "_pwm"}, 64'({pwm_red, pwm_green, pwm_blue}), 64'(exp_pwm));
    chk({tag, "_error"}, 64'(error), 64'(v.exp_err));
    chk({tag, "_state_end"}, 64'(state), 64'(0));
  endtask

  initial begin
    logic [31:0] w;
    int          n;
    vec_t        v;

    rst_n = 1'b0; in_clk = 1'b0; in_data = 1'b0; in_error = 1'b0;
    tbl[0] = mkv(10'h3FF, 10'h155, 10'h001, 1, 32, 0, 32'h0, -1, 1, 0, 2'd2, 0);
    tbl[1] = mkv(10'h2AA, 10'h0F0, 10'h3C3, 1, 32, 32, 32'hA5A5A5A5, -1, 1, 0, 2'd2, 32);
    tbl[2] = mkv(10'h111, 10'h222, 10'h333, 0, 32, 0, 32'h0, -1,
                 !PAR_EN, PAR_EN, PAR_EN ? 2'd3 : 2'd2, 0);
    tbl[3] = mkv(10'h0AB, 10'h0CD, 10'h0EF, 1, 20, 0, 32'h0, -1, 0, 1, 2'd1, 0);
    tbl[4] = mkv(10'h001, 10'h3FE, 10'h200, 1, 32, 0, 32'h0, -1, 1, 0, 2'd2, 0);
    tbl[5] = mkv(10'h155, 10'h2AA, 10'h0FF, 1, 32, 8, 32'hDEADBEEF, 5, 0, 1, 2'd3, 5);

    #12;
    chk("rst_pwm", 64'({pwm_red, pwm_green, pwm_blue}), 64'(0));
    chk("rst_pwm_set", 64'(pwm_set), 64'(0));
    chk("rst_fwd", 64'({fwd_clk, fwd_data}), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_state", 64'(state), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Exact commit latency: pwm_set appears IDLE edges after the edge sampling the last bit.
    w = mk_word(10'h3FF, 10'h155, 10'h001, 1'b1);
    fwd_q.delete();
    set_cnt = 0;
    for (int i = 0; i < 32; i++) send_bit(w[31-i], 1'b0);
    n = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (pwm_set === 1'b1) begin n = c; break; end
    end
    chk("commit_latency", 64'(n), 64'(IDLE));
    chk("commit_pwm", 64'({pwm_red, pwm_green, pwm_blue}), 64'({10'h3FF, 10'h155, 10'h001}));
    @(posedge clk); #1;
    chk("pwm_set_one_cycle", 64'(pwm_set), 64'(0));
    chk("commit_no_fwd", 64'(fwd_q.size()), 64'(0));
    chk("commit_error", 64'(error), 64'(0));
    exp_pwm = {10'h3FF, 10'h155, 10'h001};

    for (int t = 0; t < 6; t++) run_frame(tbl[t], $sformatf("vec%0d", t));

    for (int t = 0; t < 20; t++) begin
      v.r      = 10'($urandom);
      v.g      = 10'($urandom);
      v.b      = 10'($urandom);
      v.good   = ($urandom_range(0, 3) != 0);
      v.nbits  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 31)) : 32;
      v.nextra = (v.nbits == 32) ? int'($urandom_range(0, 8)) : 0;
      v.extra  = $urandom;
      v.err_at = (v.nbits == 32 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, v.nextra)) : -1;
      run_frame(model(v), $sformatf("rnd%0d", t));
    end

    // Reset in the middle of forwarding after a prior commit.
    w = mk_word(10'h123, 10'h234, 10'h345, 1'b1);
    for (int i = 0; i < 32; i++) send_bit(w[31-i], 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    chk("pre_reset_state", 64'(state), 64'(2));
    @(posedge clk); #1;
    in_clk = 1'b1; in_data = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pwm", 64'({pwm_red, pwm_green, pwm_blue}), 64'(0));
    chk("midrst_flags", 64'({pwm_set, fwd_clk, fwd_data, error}), 64'(0));
    chk("midrst_state", 64'(state), 64'(0));
    in_clk = 1'b0; in_data = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_cnt = 0;
    repeat (IDLE + 10) @(posedge clk);
    #1;
    chk("postrst_no_commit", 64'(set_cnt), 64'(0));
    chk("postrst_pwm", 64'({pwm_red, pwm_green, pwm_blue}), 64'(0));
    chk("postrst_state", 64'(state), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
